// File: rtl/game_seq_ctrl.sv
// ---------------------------------------------------------------------------
// game_seq_ctrl
//
// Top-level sequencer for a one-player bar-and-ball game. It decides when the
// animation runs and keeps the score, the remaining balls and the wait timer
// that runs between balls.
//
// States (output encoding):
//   00 NEWGAME - frozen, waiting for any button to start a game
//   01 PLAY    - animation running, hits score and misses cost a ball
//   10 NEWBALL - frozen after a miss; after the wait, a button serves again
//   11 OVER    - frozen after the last ball; after the wait, back to NEWGAME
//
// Ports
//   clk        in   1  system clock, all state changes on the rising edge
//   reset      in   1  asynchronous, active-high reset
//   btn        in   2  player buttons, level sensitive, synchronous to clk
//   refr_tick  in   1  one-clock pulse per video frame
//   hit        in   1  one-clock pulse, ball struck the bar
//   miss       in   1  one-clock pulse, ball passed the bar
//   gra_still  out  1  freezes the animation datapath when 1
//   dig1       out  4  BCD score, tens digit
//   dig0       out  4  BCD score, units digit
//   ball       out  2  balls remaining
//   state      out  2  current state, encoding above
//
// Parameters
//   LIVES        balls per game (1..3)
//   WAIT_FRAMES  frames to wait after a miss (1..255)
//
// Every output comes straight from a register or is decoded from the state
// register only, so nothing on the inputs reaches the outputs combinationally.
// ---------------------------------------------------------------------------
module game_seq_ctrl #(
    parameter int LIVES       = 3,
    parameter int WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [1:0] ball,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] W_LIVES = 2'(LIVES);
    localparam logic [7:0] W_WAIT  = 8'(WAIT_FRAMES);

    // -----------------------------------------------------------------------
    // Registers and their next values
    // -----------------------------------------------------------------------
    state_t     r_state,  w_state_next;
    logic [3:0] r_dig1,   w_dig1_next;
    logic [3:0] r_dig0,   w_dig0_next;
    logic [1:0] r_ball,   w_ball_next;
    logic [7:0] r_timer,  w_timer_next;

    logic       w_btn_any;
    logic       w_timer_zero;
    logic       w_score_max;

    assign w_btn_any    = (btn != 2'b00);
    assign w_timer_zero = (r_timer == 8'd0);
    assign w_score_max  = (r_dig1 == 4'd9) && (r_dig0 == 4'd9);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NEWGAME;
            r_dig1  <= 4'd0;
            r_dig0  <= 4'd0;
            r_ball  <= W_LIVES;
            r_timer <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_dig1  <= w_dig1_next;
            r_dig0  <= w_dig0_next;
            r_ball  <= w_ball_next;
            r_timer <= w_timer_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_dig1_next  = r_dig1;
        w_dig0_next  = r_dig0;
        w_ball_next  = r_ball;

        // Free-running frame countdown that parks at zero. A load in PLAY
        // overrides it below, so a tick on the load clock is lost.
        if (refr_tick && !w_timer_zero) begin
            w_timer_next = r_timer - 8'd1;
        end else begin
            w_timer_next = r_timer;
        end

        case (r_state)
            ST_NEWGAME: begin
                if (w_btn_any) begin
                    w_state_next = ST_PLAY;
                    w_dig1_next  = 4'd0;
                    w_dig0_next  = 4'd0;
                    w_ball_next  = W_LIVES;
                end
            end

            ST_PLAY: begin
                // A miss takes priority over a hit in the same clock.
                if (miss) begin
                    w_timer_next = W_WAIT;
                    if (r_ball > 2'd1) begin
                        w_ball_next  = r_ball - 2'd1;
                        w_state_next = ST_NEWBALL;
                    end else begin
                        w_ball_next  = 2'd0;
                        w_state_next = ST_OVER;
                    end
                end else if (hit && !w_score_max) begin
                    if (r_dig0 == 4'd9) begin
                        w_dig0_next = 4'd0;
                        w_dig1_next = r_dig1 + 4'd1;
                    end else begin
                        w_dig0_next = r_dig0 + 4'd1;
                    end
                end
            end

            ST_NEWBALL: begin
                // Uses the registered timer, so a button held while the
                // count reaches zero serves on the following clock.
                if (w_timer_zero && w_btn_any) begin
                    w_state_next = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (w_timer_zero) begin
                    w_state_next = ST_NEWGAME;
                end
            end

            default: begin
                w_state_next = ST_NEWGAME;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign gra_still = (r_state != ST_PLAY);
    assign dig1      = r_dig1;
    assign dig0      = r_dig0;
    assign ball      = r_ball;
    assign state     = r_state;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_seq_ctrl
//
// Directed game scenarios followed by randomized play, with an integer-score
// reference model updated on every clock and compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_game_seq_ctrl;

    localparam int LIVES       = 3;
    localparam int WAIT_FRAMES = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [1:0] ball;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: score as a plain integer 0..99
    int m_state = 0;   // 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
    int m_score = 0;
    int m_ball  = LIVES;
    int m_timer = 0;

    game_seq_ctrl #(
        .LIVES      (LIVES),
        .WAIT_FRAMES(WAIT_FRAMES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .refr_tick(refr_tick),
        .hit      (hit),
        .miss     (miss),
        .gra_still(gra_still),
        .dig1     (dig1),
        .dig0     (dig0),
        .ball     (ball),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Model update from the game rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_score = 0;
            m_ball  = LIVES;
            m_timer = 0;
        end else begin
            int nt;
            nt = (refr_tick && m_timer > 0) ? m_timer - 1 : m_timer;
            case (m_state)
                0: if (btn != 2'b00) begin
                       m_state = 1;
                       m_score = 0;
                       m_ball  = LIVES;
                   end
                1: if (miss) begin
                       nt = WAIT_FRAMES;
                       if (m_ball > 1) begin
                           m_ball  = m_ball - 1;
                           m_state = 2;
                       end else begin
                           m_ball  = 0;
                           m_state = 3;
                       end
                   end else if (hit && m_score < 99) begin
                       m_score = m_score + 1;
                   end
                2: if (m_timer == 0 && btn != 2'b00) m_state = 1;
                default: if (m_timer == 0) m_state = 0;
            endcase
            m_timer = nt;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        n_total++;
        if (state === 2'(m_state) && ball === 2'(m_ball) &&
            dig1 === 4'(m_score / 10) && dig0 === 4'(m_score % 10) &&
            gra_still === (m_state != 1)) begin
            n_pass++;
        end else begin
            $display("FAIL cycle t=%0t state=%0d/%0d ball=%0d/%0d score=%0d%0d/%0d still=%0b/%0b",
                     $time, state, m_state, ball, m_ball, dig1, dig0, m_score,
                     gra_still, (m_state != 1));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    endtask

    // One clock with the given inputs; returns at the following falling edge
    task automatic cyc(input logic [1:0] b, input logic rt, input logic h, input logic m);
        btn       = b;
        refr_tick = rt;
        hit       = h;
        miss      = m;
        @(negedge clk);
    endtask

    // Reset pulse entirely between two rising edges; optional immediate checks
    task automatic rst_pulse(input bit do_chk);
        #2 reset = 1'b1;
        #1;
        if (do_chk) begin
            chk("async_state", int'(state), 0);
            chk("async_still", int'(gra_still), 1);
            chk("async_ball",  int'(ball), 3);
            chk("async_score", int'(dig1) * 10 + int'(dig0), 0);
            chk("async_timer", int'(dut.r_timer), 0);
        end
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_still", int'(gra_still), 1);
        chk("reset_ball",  int'(ball), 3);
        chk("reset_score", int'(dig1) * 10 + int'(dig0), 0);
        reset = 1'b0;

        // Idle then start
        repeat (10) cyc(2'b00, 0, 0, 0);
        chk("idle_state", int'(state), 0);
        cyc(2'b01, 0, 0, 0);
        chk("start_state", int'(state), 1);
        chk("start_still", int'(gra_still), 0);
        chk("start_ball",  int'(ball), 3);
        chk("start_score", int'(dig1) * 10 + int'(dig0), 0);

        repeat (5) cyc(2'b00, 0, 1, 0);
        chk("score_05", int'(dig1) * 10 + int'(dig0), 5);

        // hit+miss+tick together: miss only, loaded timer wins
        cyc(2'b01, 1, 1, 1);
        chk("hm_score", int'(dig1) * 10 + int'(dig0), 5);
        chk("hm_ball",  int'(ball), 2);
        chk("hm_state", int'(state), 2);
        chk("hm_still", int'(gra_still), 1);
        chk("load_timer", int'(dut.r_timer), 120);

        // Button held, hits ignored while waiting
        repeat (119) cyc(2'b01, 1, 1, 0);
        chk("wait119_state", int'(state), 2);
        cyc(2'b01, 1, 0, 0);
        chk("wait120_state", int'(state), 2);
        cyc(2'b01, 0, 0, 0);
        chk("serve_state", int'(state), 1);
        chk("wait_score", int'(dig1) * 10 + int'(dig0), 5);

        repeat (7) cyc(2'b00, 0, 1, 0);
        chk("dig1_12", int'(dig1), 1);
        chk("dig0_12", int'(dig0), 2);
        repeat (86) cyc(2'b00, 0, 1, 0);
        chk("score_98", int'(dig1) * 10 + int'(dig0), 98);
        repeat (3) cyc(2'b00, 0, 1, 0);
        chk("score_sat", int'(dig1) * 10 + int'(dig0), 99);

        // Second ball lost, wait with no button, then serve
        cyc(2'b00, 0, 0, 1);
        chk("miss2_ball", int'(ball), 1);
        repeat (125) cyc(2'b00, 1, 0, 0);
        chk("nobtn_state", int'(state), 2);
        cyc(2'b10, 0, 0, 0);
        chk("serve2_state", int'(state), 1);

        // Last ball lost -> OVER, buttons irrelevant
        cyc(2'b00, 0, 0, 1);
        chk("over_state", int'(state), 3);
        chk("over_ball",  int'(ball), 0);
        repeat (120) cyc(2'b11, 1, 0, 0);
        chk("over_wait_state", int'(state), 3);
        cyc(2'b00, 0, 0, 0);
        chk("newgame_state", int'(state), 0);
        chk("kept_score", int'(dig1) * 10 + int'(dig0), 99);
        cyc(2'b01, 0, 0, 0);
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(dig1) * 10 + int'(dig0), 0);
        chk("restart_ball",  int'(ball), 3);

        // Reset mid-NEWBALL with timer at 50, then held button starts
        cyc(2'b00, 0, 1, 1);
        repeat (70) cyc(2'b00, 1, 0, 0);
        chk("timer_50", int'(dut.r_timer), 50);
        rst_pulse(1'b1);
        cyc(2'b01, 0, 0, 0);
        chk("post_rst_state", int'(state), 1);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) rst_pulse(1'b0);
            cyc(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_seq_ctrl.md
GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LIVES, default 3, balls per game (range 1..3).
REQ-002 The block SHALL have parameter WAIT_FRAMES, default 120, frames to wait after a miss (range 1..255).
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port btn  input  2  player buttons, level-sensitive, synchronous to clk.
REQ-006 The block SHALL have port refr_tick  input  1  one-clock pulse, once per video frame.
REQ-007 The block SHALL have port hit  input  1  one-clock pulse, ball struck the bar.
REQ-008 The block SHALL have port miss  input  1  one-clock pulse, ball passed the bar.
REQ-009 The block SHALL have port gra_still  output  1  freezes the animation datapath when 1.
REQ-010 The block SHALL have port dig1, dig0  output  4 each  BCD score, tens and units.
REQ-011 The block SHALL have port ball  output  2  balls remaining.
REQ-012 The block SHALL have port state  output  2  current state: 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.

Function
REQ-013 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-014 gra_still SHALL be 0 in PLAY and 1 in every other state.
REQ-015 NEWGAME SHALL transition to PLAY on the first clock with btn != 00; on that edge dig1:dig0 = 0:0 and ball = LIVES.
REQ-016 In PLAY, hit without miss SHALL add 1 to the BCD score on the next edge.
REQ-017 A units digit of 9 SHALL roll over to 0 and increment dig1.
REQ-018 A score of 99 SHALL saturate at 99.
REQ-019 In PLAY, a miss with ball > 1 SHALL decrement ball, load the timer with WAIT_FRAMES and enter NEWBALL.
REQ-020 In PLAY, a miss with ball == 1 SHALL set ball = 0, load the timer with WAIT_FRAMES and enter OVER.
REQ-021 hit and miss in the same cycle SHALL process the miss only; the score is unchanged.
REQ-022 hit or miss outside PLAY SHALL be ignored.
REQ-023 The timer (8-bit) SHALL decrement by 1 on each refr_tick while nonzero and hold at 0; a refr_tick coincident with the load SHALL be ignored, so the loaded value wins.
REQ-024 NEWBALL SHALL go to PLAY on the first clock with timer == 0 and btn != 00; a button held through expiry SHALL satisfy this.
REQ-025 Buttons in NEWBALL before expiry SHALL have no effect.
REQ-026 OVER SHALL go to NEWGAME on the first clock with timer == 0, independent of btn.
REQ-027 The score SHALL be retained through OVER and NEWGAME until the NEWGAME->PLAY edge.
REQ-028 btn in PLAY SHALL not affect the controller.
REQ-029 An illegal or unreachable state encoding SHALL return to NEWGAME on the next edge.

Reset
REQ-030 While reset = 1, asynchronously: state = NEWGAME, gra_still = 1, dig1:dig0 = 0:0, ball = LIVES, timer = 0.
REQ-031 Reset asserted mid-PLAY or mid-wait SHALL abort immediately, with no pending hit or miss applied after release.
REQ-032 The first edge after reset release SHALL evaluate NEWGAME rules, so a held btn enters PLAY on that edge.

Verification
REQ-033 Reset, btn = 00 for 10 clocks, then btn = 01 for 1 clock -> state 00 then 01, gra_still 1 -> 0, ball = 3, score 00.
REQ-034 In PLAY, 12 hit pulses -> dig1:dig0 = 1:2; preload score 98 and apply 3 hits -> 99.
REQ-035 In PLAY with ball = 3, a miss -> state 10, ball = 2, gra_still = 1; btn held, 119 refr_ticks -> still 10; 120th tick -> next edge state 01.
REQ-036 Three misses, each followed by timer expiry and btn -> after the third, state 11, ball = 0; 120 refr_ticks -> state 00, score retained; btn -> score 00, ball = 3.
REQ-037 hit and miss on the same clock at score 05 -> score stays 05, ball decremented; refr_tick on the load clock -> timer = 120.
REQ-038 Reset pulsed for 1 clock mid-NEWBALL with timer = 50 -> state 00, timer 0, ball 3, score 00 immediately, without waiting for a clock edge.
